// File: rtl/ds1302_responder.sv
// Device-side DS1302 3-wire responder: 8-byte clock bank and 31-byte RAM, single and burst access.
// Serial inputs are synchronized on csi_clk; all access is driven by host SCLK edges, with no timekeeping.
module ds1302_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       csi_clk,
  input  logic       csi_reset,
  input  logic       ser_ce,
  input  logic       ser_sclk,
  input  logic       ser_io_in,
  output logic       ser_io_out,
  output logic       ser_io_oe,
  output logic       wr_strobe,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       clock_halt
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_IGNORE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] ce_sync_q, sclk_sync_q, io_sync_q;
  logic       sclk_prev_q;
  logic       ce_s, sclk_s, io_s, sclk_rise, sclk_fall;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       ram_sel_q, ram_sel_d;
  logic [4:0] addr_q, addr_d;
  logic       burst_q, burst_d;
  logic       oe_q, oe_d, io_out_q, io_out_d;
  logic [7:0] out_q, out_d;
  logic       strobe_q, strobe_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] creg_q [8];
  logic [7:0] ram_q [31];

  logic       we;
  logic       wr_ok;
  logic [7:0] byte_in, rd_cur, rd_nxt;
  logic [4:0] addr_next;

  assign ce_s      = ce_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign io_s      = io_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign byte_in   = {io_s, shift_q};

  function automatic logic [7:0] rd_byte(input logic sel, input logic [4:0] a);
    rd_byte = 8'h00;
    if (sel) begin
      if (a != 5'd31) rd_byte = ram_q[a];
    end else if (a[4:3] == 2'b00) begin
      rd_byte = creg_q[a[2:0]];
    end
  endfunction

  // Clock burst wraps at 8 registers, RAM burst at 31 bytes.
  assign addr_next = ram_sel_q ? ((addr_q == 5'd30) ? 5'd0 : addr_q + 5'd1)
                               : {2'b00, addr_q[2:0] + 3'd1};
  assign rd_cur = rd_byte(ram_sel_q, addr_q);
  assign rd_nxt = rd_byte(ram_sel_q, addr_next);
  assign wr_ok  = (ram_sel_q ? (addr_q != 5'd31) : (addr_q[4:3] == 2'b00)) &&
                  (!creg_q[7][7] || (!ram_sel_q && addr_q == 5'd7));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ram_sel_d = ram_sel_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    oe_d      = oe_q;
    io_out_d  = io_out_q;
    out_d     = out_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    we        = 1'b0;
    if (state_q != S_IDLE && !ce_s) begin
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
      io_out_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          bit_cnt_d = 3'd0;
          oe_d      = 1'b0;
          io_out_d  = 1'b0;
          if (ce_s) state_d = S_CMD;
        end
        S_CMD: if (sclk_rise) begin
          shift_d   = byte_in[7:1];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (!byte_in[7]) begin
              state_d = S_IGNORE;
            end else begin
              ram_sel_d = byte_in[6];
              burst_d   = &byte_in[5:1];
              addr_d    = (&byte_in[5:1]) ? 5'd0 : byte_in[5:1];
              state_d   = byte_in[0] ? S_RDATA : S_WDATA;
            end
          end
        end
        S_WDATA: if (sclk_rise) begin
          shift_d   = byte_in[7:1];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (wr_ok) begin
              we        = 1'b1;
              strobe_d  = 1'b1;
              wr_addr_d = {ram_sel_q, addr_q};
              wr_data_d = byte_in;
            end
            if (burst_q) addr_d = addr_next;
            else         state_d = S_IGNORE;
          end
        end
        S_RDATA: if (sclk_fall) begin
          // bit_cnt == 0 with oe already high means a full byte has been shifted out.
          if (!oe_q) begin
            oe_d      = 1'b1;
            io_out_d  = rd_cur[0];
            out_d     = {1'b0, rd_cur[7:1]};
            bit_cnt_d = 3'd1;
          end else if (bit_cnt_q != 3'd0) begin
            io_out_d  = out_q[0];
            out_d     = {1'b0, out_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (burst_q) begin
            addr_d    = addr_next;
            io_out_d  = rd_nxt[0];
            out_d     = {1'b0, rd_nxt[7:1]};
            bit_cnt_d = 3'd1;
          end else begin
            oe_d     = 1'b0;
            io_out_d = 1'b0;
            state_d  = S_IGNORE;
          end
        end
        S_IGNORE: begin
          oe_d     = 1'b0;
          io_out_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      ce_sync_q   <= '0;
      sclk_sync_q <= '0;
      io_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      ram_sel_q   <= 1'b0;
      addr_q      <= 5'd0;
      burst_q     <= 1'b0;
      oe_q        <= 1'b0;
      io_out_q    <= 1'b0;
      out_q       <= 8'd0;
      strobe_q    <= 1'b0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= 8'd0;
    end else begin
      ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], ser_ce};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ser_sclk};
      io_sync_q   <= {io_sync_q[SYNC_STAGES-2:0], ser_io_in};
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ram_sel_q   <= ram_sel_d;
      addr_q      <= addr_d;
      burst_q     <= burst_d;
      oe_q        <= oe_d;
      io_out_q    <= io_out_d;
      out_q       <= out_d;
      strobe_q    <= strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      creg_q[0] <= 8'h80;
      for (int i = 1; i < 8; i++) creg_q[i] <= 8'h00;
      for (int i = 0; i < 31; i++) ram_q[i] <= 8'h00;
    end else if (we) begin
      if (ram_sel_q) ram_q[addr_q]        <= byte_in;
      else           creg_q[addr_q[2:0]] <= byte_in;
    end
  end

  assign ser_io_out = io_out_q;
  assign ser_io_oe  = oe_q;
  assign wr_strobe  = strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign clock_halt = creg_q[0][7];

endmodule

// File: tb/tb_ds1302_responder.sv
// Scoreboard bench for ds1302_responder: stimulus queues expected writes, read bytes and oe windows.
module tb_ds1302_responder;

  logic       csi_clk = 1'b0;
  logic       csi_reset, ser_ce, ser_sclk, ser_io_in;
  logic       ser_io_out, ser_io_oe, wr_strobe, clock_halt;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  ds1302_responder #(.SYNC_STAGES(2)) dut (
    .csi_clk(csi_clk), .csi_reset(csi_reset), .ser_ce(ser_ce), .ser_sclk(ser_sclk),
    .ser_io_in(ser_io_in), .ser_io_out(ser_io_out), .ser_io_oe(ser_io_oe),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .clock_halt(clock_halt)
  );

  always #5 csi_clk = ~csi_clk;

  localparam int HP = 6;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  int          exp_win [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge csi_clk);
  endtask

  task automatic ce_on();
    ser_ce = 1'b1;
    tick(HP);
  endtask

  task automatic ce_off();
    tick(HP);
    ser_ce = 1'b0;
    tick(HP + 2);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      ser_io_in = b[i];
      tick(HP);
      ser_sclk = 1'b1;
      tick(HP);
      ser_sclk = 1'b0;
    end
  endtask

  task automatic recv_bits(input int n);
    for (int i = 0; i < n; i++) begin
      tick(HP);
      ser_sclk = 1'b1;
      tick(HP);
      ser_sclk = 1'b0;
    end
  endtask

  task automatic do_write(input logic [7:0] cmd, input logic [7:0] data, input bit strobe_exp);
    if (strobe_exp) exp_wr.push_back({cmd[6], cmd[5:1], data});
    ce_on();
    send_bits(cmd, 8);
    send_bits(data, 8);
    ce_off();
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [7:0] exp_byte);
    exp_rd.push_back(exp_byte);
    exp_win.push_back(8);
    ce_on();
    send_bits(cmd, 8);
    recv_bits(8);
    ce_off();
  endtask

  // Write-strobe and oe-window monitor.
  logic oe_prev = 1'b0;
  int   win_cnt = 0;
  int   bit_n   = 0;
  logic [7:0] rd_sh = 8'h00;
  logic [13:0] e_wr;

  always @(negedge csi_clk) begin
    if (wr_strobe) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
      end else begin
        e_wr = exp_wr.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e_wr[13:8]));
        check("wr_data", 32'(wr_data), 32'(e_wr[7:0]));
      end
    end
    if (oe_prev && !ser_io_oe) begin
      if (exp_win.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_oe_window: got %0d slots expected none", win_cnt);
      end else begin
        check("oe_window", 32'(win_cnt), 32'(exp_win.pop_front()));
      end
      win_cnt = 0;
      bit_n   = 0;
    end
    oe_prev = ser_io_oe;
  end

  always @(posedge ser_sclk) begin
    if (ser_io_oe) begin
      rd_sh = {ser_io_out, rd_sh[7:1]};
      win_cnt++;
      bit_n++;
      if (bit_n == 8) begin
        bit_n = 0;
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got 0x%0h expected none", rd_sh);
        end else begin
          check("rd_byte", 32'(rd_sh), 32'(exp_rd.pop_front()));
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    csi_reset = 1'b1;
    ser_ce    = 1'b0;
    ser_sclk  = 1'b0;
    ser_io_in = 1'b0;
    tick(4);
    csi_reset = 1'b0;
    tick(2);
    check("rst_oe", 32'(ser_io_oe), 0);
    check("rst_io_out", 32'(ser_io_out), 0);
    check("rst_strobe", 32'(wr_strobe), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_clock_halt", 32'(clock_halt), 1);

    do_read(8'h81, 8'h80);

    do_write(8'hCA, 8'h3C, 1'b1);
    do_read(8'hCB, 8'h3C);

    do_write(8'h8E, 8'h80, 1'b1);
    do_write(8'h84, 8'h12, 1'b0);
    do_read(8'h85, 8'h00);
    do_write(8'h8E, 8'h00, 1'b1);
    do_write(8'h84, 8'h12, 1'b1);
    do_read(8'h85, 8'h12);

    // RAM burst of 32 bytes: the 32nd wraps to RAM[0].
    for (int i = 0; i < 32; i++)
      exp_wr.push_back({1'b1, 5'(i % 31), 8'(i + 1)});
    ce_on();
    send_bits(8'hFE, 8);
    for (int i = 0; i < 32; i++) send_bits(8'(i + 1), 8);
    ce_off();
    do_read(8'hC1, 8'h20);
    do_read(8'hCB, 8'h06);
    do_read(8'hFD, 8'h1F);

    for (int a = 0; a < 8; a++)
      do_write(8'h80 | 8'(a << 1), 8'h10 + 8'(a), 1'b1);
    check("clock_halt_cleared", 32'(clock_halt), 0);

    for (int i = 0; i < 9; i++) exp_rd.push_back(8'h10 + 8'(i % 8));
    exp_win.push_back(72);
    ce_on();
    send_bits(8'hBF, 8);
    recv_bits(72);
    ce_off();

    ce_on();
    send_bits(8'hC2, 8);
    send_bits(8'hAA, 4);
    ce_off();
    do_read(8'hC3, 8'h02);

    ce_on();
    send_bits(8'h0A, 8);
    send_bits(8'hFF, 8);
    ce_off();
    do_read(8'h8B, 8'h15);

    csi_reset = 1'b1;
    tick(2);
    csi_reset = 1'b0;
    tick(2);
    check("reset_clock_halt", 32'(clock_halt), 1);
    do_read(8'hC3, 8'h00);

    tick(20);
    check("wr_queue_empty", 32'(exp_wr.size()), 0);
    check("rd_queue_empty", 32'(exp_rd.size()), 0);
    check("win_queue_empty", 32'(exp_win.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
